// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - MIPS multiply/divide controller: HI/LO ownership, busy timing, D-stage stall
module mdu_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op_E,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  input  logic        md_use_D,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_md
);

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        busy_q, busy_d;

  logic               start_op;
  logic               div_zero;
  logic               div_ovf;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] den_s, quo_s, rem_s;
  logic [31:0]        den_u, quo_u, rem_u;
  logic [63:0]        result;

  assign start_op = (md_op_E >= OP_MULT) && (md_op_E <= OP_DIVU);
  assign div_zero = (rt_E == 32'd0);
  assign div_ovf  = (rs_E == 32'h8000_0000) && (rt_E == 32'hFFFF_FFFF);

  assign prod_s = $signed({{32{rs_E[31]}}, rs_E}) * $signed({{32{rt_E[31]}}, rt_E});
  assign prod_u = {32'd0, rs_E} * {32'd0, rt_E};

  // A divisor of 1 sidesteps the zero and overflow cases; 0x80000000/1 is exactly the required overflow result.
  assign den_s = (div_zero || div_ovf) ? 32'sd1 : $signed(rt_E);
  assign quo_s = $signed(rs_E) / den_s;
  assign rem_s = $signed(rs_E) % den_s;
  assign den_u = div_zero ? 32'd1 : rt_E;
  assign quo_u = rs_E / den_u;
  assign rem_u = rs_E % den_u;

  always_comb begin
    result = {hi_q, lo_q};
    case (md_op_E)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV:   result = div_zero ? {hi_q, lo_q} : {rem_s, quo_s};
      OP_DIVU:  result = div_zero ? {hi_q, lo_q} : {rem_u, quo_u};
      default:  result = {hi_q, lo_q};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        if (start_op) begin
          pend_hi_d = result[63:32];
          pend_lo_d = result[31:0];
          cnt_d     = (md_op_E <= OP_MULTU) ? 4'(MULT_CYC) : 4'(DIV_CYC);
          state_d   = BUSY;
          busy_d    = 1'b1;
        end else if (md_op_E == OP_MTHI) begin
          hi_d = rs_E;
        end else if (md_op_E == OP_MTLO) begin
          lo_d = rs_E;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      busy_q    <= busy_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  // Start cycle is covered too, so a back-to-back MDU op cannot slip into E before busy rises.
  assign stall_md = md_use_D & (busy_q | start_op);

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - self-checking bench for mdu_ctrl with an expected-result scoreboard
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic [2:0]  md_op_E;
  logic [31:0] rs_E;
  logic [31:0] rt_E;
  logic        md_use_D;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall_md;

  int compared;
  int mismatched;
  logic [63:0] exp_q[$];

  mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk),
    .reset(reset),
    .md_op_E(md_op_E),
    .rs_E(rs_E),
    .rt_E(rt_E),
    .md_use_D(md_use_D),
    .hi(hi),
    .lo(lo),
    .busy(busy),
    .stall_md(stall_md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Issue one mult/div op, count busy cycles, then pop the expected {hi,lo} at completion.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic use_d, input int ncyc,
                       input logic [63:0] expv);
    int n;
    logic [63:0] e;
    @(posedge clk); #1;
    md_op_E  = op;
    rs_E     = a;
    rt_E     = b;
    md_use_D = use_d;
    exp_q.push_back(expv);
    @(negedge clk);
    chk({tag, "_stall_start"}, {63'd0, stall_md}, {63'd0, use_d});
    chk({tag, "_busy_pre"}, {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    md_op_E = 3'd0;
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      n++;
      if (stall_md !== use_d)
        chk({tag, "_stall_busy"}, {63'd0, stall_md}, {63'd0, use_d});
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'(ncyc));
    e = exp_q.pop_front();
    chk({tag, "_hilo"}, {hi, lo}, e);
    chk({tag, "_stall_after"}, {63'd0, stall_md}, 64'd0);
    md_use_D = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
    md_op_E    = 3'd0;
    rs_E       = 32'd0;
    rt_E       = 32'd0;
    md_use_D   = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_stall", {63'd0, stall_md}, 64'd0);
    reset    = 1'b1;
    md_use_D = 1'b0;

    do_op("mult_neg", 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, 5, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    do_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5, {32'hFFFF_FFFE, 32'h0000_0001});
    do_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 10, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10, {32'h0000_0000, 32'h8000_0000});

    @(posedge clk); #1;
    md_op_E = 3'd5; rs_E = 32'h1111_1111;
    @(posedge clk); #1;
    md_op_E = 3'd6; rs_E = 32'h2222_2222;
    @(posedge clk); #1;
    md_op_E = 3'd0;
    @(negedge clk);
    chk("mt_hilo", {hi, lo}, {32'h1111_1111, 32'h2222_2222});
    chk("mt_busy", {63'd0, busy}, 64'd0);

    do_op("divu_zero", 3'd4, 32'd55, 32'd0, 1'b1, 10, {32'h1111_1111, 32'h2222_2222});
    do_op("divu_7", 3'd4, 32'd100, 32'd7, 1'b0, 10, {32'd2, 32'd14});

    // Ops reaching E while busy must be ignored.
    @(posedge clk); #1;
    md_op_E = 3'd1; rs_E = 32'd4; rt_E = 32'd5;
    @(posedge clk); #1;
    md_op_E = 3'd5; rs_E = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    md_op_E = 3'd0;
    repeat (6) @(negedge clk);
    chk("busy_ignore_hilo", {hi, lo}, {32'd0, 32'd20});
    chk("busy_ignore_idle", {63'd0, busy}, 64'd0);

    // Abort a div at busy cycle 3 with an asynchronous reset.
    @(posedge clk); #1;
    md_op_E = 3'd3; rs_E = 32'd90; rt_E = 32'd9;
    @(posedge clk); #1;
    md_op_E = 3'd0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", {63'd0, busy}, 64'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_hilo", {hi, lo}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    do_op("mult_after_rst", 3'd1, 32'd7, 32'd6, 1'b1, 5, {32'd0, 32'd42});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
